// File: rtl/haz_ctrl_sb_if.sv
// ---------------------------------------------------------------------------
// haz_ctrl_sb_if : signal bundle between the decode stage and the
//                  scoreboard hazard controller (haz_ctrl_sb).
//
// Parameters
//   REG_W  register-address width
//   CNT_W  stall-counter width
//
// Signals (direction seen from the controller, i.e. the slave modport)
//   in  mem_en_ID_EX, mem_wr_ID_EX, w1_reg_ID_EX  instruction leaving ID/EX
//   in  read_reg1/2, rd1_vld/rd2_vld, id_is_load  instruction sitting in IF/ID
//   in  mem_busy                                  data-cache miss in progress
//   in  ld_done, ld_done_reg                      load data return
//   out pause_pc, wrt_IF_ID, bubble_ID_EX, freeze_pipe  pipeline control
//   out stall_cnt                                 stall-cycle count
//   out fsm_state                                 controller status, debug only
//
// The master modport is the decode/pipeline side that drives the inputs.
// ---------------------------------------------------------------------------
interface haz_ctrl_sb_if #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
);
    logic             mem_en_ID_EX;
    logic             mem_wr_ID_EX;
    logic [REG_W-1:0] w1_reg_ID_EX;
    logic [REG_W-1:0] read_reg1;
    logic [REG_W-1:0] read_reg2;
    logic             rd1_vld;
    logic             rd2_vld;
    logic             id_is_load;
    logic             mem_busy;
    logic             ld_done;
    logic [REG_W-1:0] ld_done_reg;
    logic             pause_pc;
    logic             wrt_IF_ID;
    logic             bubble_ID_EX;
    logic             freeze_pipe;
    logic [CNT_W-1:0] stall_cnt;
    logic [1:0]       fsm_state;

    modport master (
        output mem_en_ID_EX, mem_wr_ID_EX, w1_reg_ID_EX,
        output read_reg1, read_reg2, rd1_vld, rd2_vld, id_is_load,
        output mem_busy, ld_done, ld_done_reg,
        input  pause_pc, wrt_IF_ID, bubble_ID_EX, freeze_pipe, stall_cnt, fsm_state
    );

    modport slave (
        input  mem_en_ID_EX, mem_wr_ID_EX, w1_reg_ID_EX,
        input  read_reg1, read_reg2, rd1_vld, rd2_vld, id_is_load,
        input  mem_busy, ld_done, ld_done_reg,
        output pause_pc, wrt_IF_ID, bubble_ID_EX, freeze_pipe, stall_cnt, fsm_state
    );
endinterface

// File: rtl/haz_ctrl_sb.sv
// ---------------------------------------------------------------------------
// haz_ctrl_sb : decode-stage hazard controller with a load scoreboard.
//
// Every load leaving ID/EX marks its destination register pending until its
// data returns (ld_done). An IF/ID instruction that reads a pending register,
// or the register of a load leaving ID/EX this very cycle, is held in IF/ID
// while a NOP goes into ID/EX. A data-cache miss freezes the whole pipe.
// A load in IF/ID also waits while the number of loads in flight is already
// at MAX_PEND, unless one of them returns this cycle.
//
// Ports
//   clk, rst   clock, synchronous active-high reset
//   bus        haz_ctrl_sb_if.slave (decode inputs, pipeline-control outputs)
//
// Parameters
//   REG_W     register-address width (scoreboard holds 2**REG_W entries)
//   MAX_PEND  maximum loads in flight, 1..7
//   CNT_W     stall-counter width
//
// Optional feature
//   HAZ_STALL_CNT_EN  when defined, stall_cnt counts cycles with pause_pc=1
//                     (saturating); when undefined stall_cnt is tied to 0.
// ---------------------------------------------------------------------------
module haz_ctrl_sb #(
    parameter int REG_W    = 3,
    parameter int MAX_PEND = 2,
    parameter int CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    haz_ctrl_sb_if.slave bus
);

    localparam int NREG = 1 << REG_W;
    localparam int PC_W = $clog2(MAX_PEND + 1);
    localparam logic [PC_W-1:0] PC_MAX = PC_W'(MAX_PEND);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_LDUSE = 2'd1;
    localparam logic [1:0] ST_MISS  = 2'd2;

    logic [NREG-1:0] r_pend;
    logic [PC_W-1:0] r_pcnt;
    logic [1:0]      r_state;

    logic [NREG-1:0] w_pend_nxt;
    logic [PC_W-1:0] w_pcnt_nxt;
    logic [1:0]      w_state_nxt;
    logic            w_issue;
    logic            w_haz_src1;
    logic            w_haz_src2;
    logic            w_haz_full;
    logic            w_haz;
    logic            w_pause;
    logic            w_wrt;
    logic            w_bubble;
    logic            w_freeze;

    // A load only leaves ID/EX when the pipe is not frozen by a miss.
    assign w_issue = bus.mem_en_ID_EX & ~bus.mem_wr_ID_EX & ~bus.mem_busy;

    // Pending-register hit, plus forward check against the load leaving now
    // (its scoreboard bit is not visible until the next clock).
    assign w_haz_src1 = bus.rd1_vld & (r_pend[bus.read_reg1] |
                        (w_issue & (bus.w1_reg_ID_EX == bus.read_reg1)));
    assign w_haz_src2 = bus.rd2_vld & (r_pend[bus.read_reg2] |
                        (w_issue & (bus.w1_reg_ID_EX == bus.read_reg2)));
    // A returning load frees a slot this cycle, so a full scoreboard does not block then.
    assign w_haz_full = bus.id_is_load & (r_pcnt == PC_MAX) & ~bus.ld_done;
    assign w_haz      = w_haz_src1 | w_haz_src2 | w_haz_full;

    // Outputs are purely combinational; reset forces the free-running values.
    always_comb begin
        w_pause  = 1'b0;
        w_wrt    = 1'b1;
        w_bubble = 1'b0;
        w_freeze = 1'b0;
        if (!rst) begin
            if (bus.mem_busy) begin
                w_pause  = 1'b1;
                w_wrt    = 1'b0;
                w_freeze = 1'b1;
            end else if (w_haz) begin
                w_pause  = 1'b1;
                w_wrt    = 1'b0;
                w_bubble = 1'b1;
            end
        end
    end

    assign bus.pause_pc     = w_pause;
    assign bus.wrt_IF_ID    = w_wrt;
    assign bus.bubble_ID_EX = w_bubble;
    assign bus.freeze_pipe  = w_freeze;
    assign bus.fsm_state    = r_state;

    // Clear first so a set of the same register in the same cycle wins.
    always_comb begin
        w_pend_nxt = r_pend;
        if (bus.ld_done)
            w_pend_nxt[bus.ld_done_reg] = 1'b0;
        if (w_issue)
            w_pend_nxt[bus.w1_reg_ID_EX] = 1'b1;
    end

    // Count is clamped at both ends: a return with nothing in flight is ignored.
    always_comb begin
        w_pcnt_nxt = r_pcnt;
        case ({w_issue, bus.ld_done})
            2'b10: if (r_pcnt != PC_MAX) w_pcnt_nxt = r_pcnt + PC_W'(1);
            2'b01: if (r_pcnt != '0)     w_pcnt_nxt = r_pcnt - PC_W'(1);
            default: w_pcnt_nxt = r_pcnt;
        endcase
    end

    always_comb begin
        w_state_nxt = ST_RUN;
        if (bus.mem_busy)
            w_state_nxt = ST_MISS;
        else if (w_haz)
            w_state_nxt = ST_LDUSE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend  <= '0;
            r_pcnt  <= '0;
            r_state <= ST_RUN;
        end else begin
            r_pend  <= w_pend_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_state <= w_state_nxt;
        end
    end

`ifdef HAZ_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (w_pause)
            r_stall_cnt <= sat_inc(r_stall_cnt);
    end

    assign bus.stall_cnt = r_stall_cnt;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_haz_ctrl_sb.sv
// ---------------------------------------------------------------------------
// tb_haz_ctrl_sb : directed-vector bench for haz_ctrl_sb. The driver applies
// one vector per clock and queues the hand-computed control outputs; a
// separate monitor pops and compares them on the falling edge.
// ---------------------------------------------------------------------------
module tb_haz_ctrl_sb;

    localparam int REG_W    = 3;
    localparam int MAX_PEND = 2;
    localparam int CNT_W    = 4;

    // Expected control word order: {pause_pc, wrt_IF_ID, bubble_ID_EX, freeze_pipe}
    localparam logic [3:0] IDLE  = 4'b0100;
    localparam logic [3:0] STALL = 4'b1010;
    localparam logic [3:0] FRZ   = 4'b1001;

    typedef struct {
        string            name;
        logic [3:0]       ctl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stim_vld = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    logic [CNT_W-1:0] cnt_model = '0;

    haz_ctrl_sb_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    haz_ctrl_sb #(
        .REG_W   (REG_W),
        .MAX_PEND(MAX_PEND),
        .CNT_W   (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // One vector per cycle: apply inputs just after the edge, queue expectation,
    // then advance the stall-count model over the coming edge.
    task automatic drive(input string name,
                         input logic men, input logic mwr, input logic [REG_W-1:0] w1,
                         input logic [REG_W-1:0] r1, input logic v1,
                         input logic [REG_W-1:0] r2, input logic v2,
                         input logic idl, input logic busy,
                         input logic ldd, input logic [REG_W-1:0] ldr,
                         input logic rs, input logic [3:0] exp_ctl);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = rs;
        bus.mem_en_ID_EX = men;
        bus.mem_wr_ID_EX = mwr;
        bus.w1_reg_ID_EX = w1;
        bus.read_reg1    = r1;
        bus.rd1_vld      = v1;
        bus.read_reg2    = r2;
        bus.rd2_vld      = v2;
        bus.id_is_load   = idl;
        bus.mem_busy     = busy;
        bus.ld_done      = ldd;
        bus.ld_done_reg  = ldr;
        stim_vld         = 1'b1;
        e.name = name;
        e.ctl  = exp_ctl;
`ifdef HAZ_STALL_CNT_EN
        e.cnt  = cnt_model;
        if (rs)
            cnt_model = '0;
        else if (exp_ctl[3] && cnt_model != {CNT_W{1'b1}})
            cnt_model = cnt_model + 1'b1;
`else
        e.cnt  = '0;
`endif
        sb_q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so compare mid-cycle.
    always @(negedge clk) begin
        if (stim_vld) begin
            if (sb_q.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL sb_underflow: monitor had no expected entry");
            end else begin
                exp_t e;
                logic [3:0] act;
                e   = sb_q.pop_front();
                act = {bus.pause_pc, bus.wrt_IF_ID, bus.bubble_ID_EX, bus.freeze_pipe};
                checks = checks + 1;
                if (act !== e.ctl || bus.stall_cnt !== e.cnt) begin
                    errors = errors + 1;
                    $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                             e.name, act, bus.stall_cnt, e.ctl, e.cnt);
                end
            end
        end
    end

    initial begin
        bus.mem_en_ID_EX = 0; bus.mem_wr_ID_EX = 0; bus.w1_reg_ID_EX = 0;
        bus.read_reg1 = 0; bus.rd1_vld = 0; bus.read_reg2 = 0; bus.rd2_vld = 0;
        bus.id_is_load = 0; bus.mem_busy = 0; bus.ld_done = 0; bus.ld_done_reg = 0;
        repeat (2) @(posedge clk);

        //     name            men mwr w1 r1 v1 r2 v2 idl bsy ldd ldr rst exp
        drive("rst_busy_idle",  1, 0, 3, 3, 1, 0, 0, 1, 1, 0, 0, 1, IDLE);
        // 1: load-use on R3, released the cycle after data returns
        drive("t1_issue_fwd",   1, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, STALL);
        drive("t1_pend_hold",   0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, STALL);
        drive("t1_ret_still",   0, 0, 0, 3, 1, 0, 0, 0, 0, 1, 3, 0, STALL);
        drive("t1_released",    0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, IDLE);
        // 2: unrelated source, unused source, stores ignored
        drive("t2_no_dep",      1, 0, 3, 5, 1, 3, 0, 0, 0, 0, 0, 0, IDLE);
        drive("t2_src2_pend",   0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, STALL);
        drive("t2_store_fwd",   1, 1, 4, 4, 1, 0, 0, 0, 0, 0, 0, 0, IDLE);
        drive("t2_store_nopend",0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, IDLE);
        // 3: miss with a hazard present: freeze wins, no issue while busy
        for (int i = 0; i < 4; i++)
            drive("t3_miss_freeze", 1, 0, 6, 3, 1, 0, 0, 0, 1, 0, 0, 0, FRZ);
        drive("t3_no_set_busy", 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, IDLE);
        // 4: MAX_PEND=2 limit for a load in IF/ID
        drive("t4_issue_r6",    1, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        drive("t4_full_stall",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, STALL);
        drive("t4_full_retfree",1, 0, 7, 0, 0, 0, 0, 1, 0, 1, 3, 0, IDLE);
        drive("t4_still_full",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, STALL);
        drive("t4_pend_r7",     0, 0, 0, 7, 1, 0, 0, 0, 0, 1, 6, 0, STALL);
        drive("t4_not_full",    0, 0, 0, 6, 1, 0, 0, 1, 0, 0, 0, 0, IDLE);
        // 5: set beats clear on same reg; reset mid-stall drops everything
        drive("t5_set_clr_r2",  1, 0, 2, 0, 0, 0, 0, 0, 0, 1, 2, 0, IDLE);
        drive("t5_r2_pend",     0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, STALL);
        drive("t5_rst_mid",     0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 1, IDLE);
        drive("t5_after_rst",   0, 0, 0, 7, 1, 2, 1, 1, 0, 0, 0, 0, IDLE);
        // Return with nothing in flight must not underflow the count
        drive("t7_ret_empty",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, IDLE);
        drive("t7_issue_r1",    1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        drive("t7_issue_r4",    1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);
        drive("t7_full_stall",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, STALL);
        drive("t7_ret_r1",      0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, IDLE);
        drive("t7_ret_r4",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, IDLE);
        drive("t7_empty_load",  0, 0, 0, 4, 1, 1, 1, 1, 0, 0, 0, 0, IDLE);
        // 6: long miss drives the counter into saturation
        for (int i = 0; i < 20; i++)
            drive("t6_long_miss", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, FRZ);
        drive("t6_cnt_final",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE);

        @(posedge clk);
        #1;
        stim_vld = 1'b0;
        if (sb_q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL sb_leftover: %0d entries unchecked, expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
